// File: rtl/demultiplex_pkg.sv
// Shared types and token-layout helpers for the burst demultiplexer.
package demultiplex_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    // Select token width: destination index plus one broadcast flag bit.
    function automatic int sel_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // The broadcast flag sits directly above the destination index.
    function automatic int bcast_bit(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/demultiplex_burst_hold.sv
// One-entry stb/ack output register. A load in the same cycle as a drain
// replaces the word and keeps stb high, so a draining register still
// accepts a word every cycle.
module hold #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_i,
    input  logic [W-1:0] dat_i,
    output logic         space_o,
    output logic [W-1:0] m_dat_o,
    output logic         m_stb_o,
    input  logic         m_ack_i
);

    logic [W-1:0] dat_q, dat_d;
    logic         stb_q, stb_d;

    // Next state: load wins over drain; data only changes on a load.
    always_comb begin
        dat_d = dat_q;
        stb_d = stb_q;
        if (ld_i) begin
            dat_d = dat_i;
            stb_d = 1'b1;
        end else if (m_ack_i) begin
            stb_d = 1'b0;
        end
    end

    // Register with asynchronous active-low clear of both word and valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dat_q <= '0;
            stb_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            stb_q <= stb_d;
        end
    end

    assign space_o = !stb_q || m_ack_i;
    assign m_dat_o = dat_q;
    assign m_stb_o = stb_q;

endmodule

// File: rtl/demultiplex_burst.sv
// Burst demultiplexer: a select token routes the next L input words to one
// output channel, to all channels (broadcast), or to nowhere (index >= N).
module demultiplex_burst
    import demultiplex_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned N = 4,
    parameter int unsigned L = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [W-1:0]              s_dat,
    input  logic                      s_stb,
    output logic                      s_ack,
    input  logic [sel_width(N)-1:0]   n_dat,
    input  logic                      n_stb,
    output logic                      n_ack,
    output logic [N-1:0][W-1:0]       m_dat,
    output logic [N-1:0]              m_stb,
    input  logic [N-1:0]              m_ack
);

    localparam int IW    = $clog2(N);
    localparam int BCAST = bcast_bit(N);
    localparam int CW    = $clog2(L) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] dest_q, dest_d;
    logic          bcast_q, bcast_d;

    logic [N-1:0]  tgt;
    logic [N-1:0]  space;
    logic [N-1:0]  ld;
    logic          sink;
    logic          all_space;
    logic          s_xfer;

    // Target decode from the latched token; an out-of-range index is a sink.
    always_comb begin
        sink = !bcast_q && (int'(dest_q) >= int'(N));
        for (int c = 0; c < int'(N); c++) begin
            tgt[c] = bcast_q || (int'(dest_q) == c);
        end
    end

    // Broadcast is atomic: every targeted channel must have space at once.
    assign all_space = &(space | ~tgt);
    assign n_ack     = rst && (state_q == IDLE);
    assign s_ack     = rst && (state_q == BURST) && (sink ? s_stb : all_space);
    assign s_xfer    = s_stb && s_ack;
    assign ld        = tgt & {N{s_xfer}};

    // FSM next state: latch token in IDLE, count words in BURST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        bcast_d = bcast_q;
        case (state_q)
            IDLE: begin
                if (n_stb) begin
                    dest_d  = n_dat[IW-1:0];
                    bcast_d = n_dat[BCAST];
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (s_xfer) begin
                    if (cnt_q == CW'(L - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, counter and token registers; reset abandons any open burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dest_q  <= '0;
            bcast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            bcast_q <= bcast_d;
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_ch
        hold #(.W(W)) u_hold (
            .clk     (clk),
            .rst     (rst),
            .ld_i    (ld[g]),
            .dat_i   (s_dat),
            .space_o (space[g]),
            .m_dat_o (m_dat[g]),
            .m_stb_o (m_stb[g]),
            .m_ack_i (m_ack[g])
        );
    end

endmodule
